// File: rtl/sha2_pkg.sv
// Shared SHA-2 definitions: round constants, initial hash values, FSM state type
// and the bitwise helper functions used by the round logic and message schedule.
package sha2_pkg;

  typedef enum logic [2:0] {IDLE, READ, COMPUTE, UPDATE, WRITE, DONE} state_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] IV224 [0:7] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] s0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] S0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] S1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/sha2_round.sv
// One combinational SHA-2 compression round: working variables a..h plus the
// scheduled word and round constant produce the next working variables.
module sha2_round
  import sha2_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] c,
  input  logic [31:0] d,
  input  logic [31:0] e,
  input  logic [31:0] f,
  input  logic [31:0] g,
  input  logic [31:0] h,
  input  logic [31:0] w,
  input  logic [31:0] k,
  output logic [31:0] a_next,
  output logic [31:0] b_next,
  output logic [31:0] c_next,
  output logic [31:0] d_next,
  output logic [31:0] e_next,
  output logic [31:0] f_next,
  output logic [31:0] g_next,
  output logic [31:0] h_next
);

  logic [31:0] t1;
  logic [31:0] t2;

  assign t1 = h + S1(e) + ch(e, f, g) + k + w;
  assign t2 = S0(a) + maj(a, b, c);

  assign a_next = t1 + t2;
  assign b_next = a;
  assign c_next = b;
  assign d_next = c;
  assign e_next = d + t1;
  assign f_next = e;
  assign g_next = f;
  assign h_next = g;

endmodule

// File: rtl/sha2_engine.sv
// SHA-256 hashing coprocessor with hardware padding and memory-mapped digest write-back.
// Define SHA2_SHA224_EN to honour the mode input (SHA-224 IV and 7-word digest).
module sha2_engine
  import sha2_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int MSG_W  = 32
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [MSG_W-1:0]  message_addr,
  input  logic [31:0]       size,
  input  logic [MSG_W-1:0]  output_addr,
  output logic              done,
  output logic              busy,
  output logic              mem_clk,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_write_data,
  input  logic [31:0]       mem_read_data
);

  state_t            state, state_nxt;
  logic [6:0]        cnt;
  logic [ADDR_W-1:0] msg_base, out_base;
  logic [31:0]       size_r, nblk_r, blk_r;
  logic [31:0]       hv     [0:7];
  logic [31:0]       st     [0:7];
  logic [31:0]       st_nxt [0:7];
  logic [31:0]       wv     [0:15];
  logic [31:0]       w_new, w_pad, k_t;
  logic [3:0]        nw;
  logic              mode_in, last_blk, more_blk;
  logic              unused_bits;

  assign unused_bits = ^{message_addr, output_addr, mode};
  assign mem_clk     = clk;

`ifdef SHA2_SHA224_EN
  logic mode_r;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      mode_r <= 1'b0;
    else if (state == IDLE && start)
      mode_r <= mode;
  end
  assign mode_in = mode;
  assign nw      = mode_r ? 4'd7 : 4'd8;
`else
  assign mode_in = 1'b0;
  assign nw      = 4'd8;
`endif

  function automatic logic [31:0] iv_word(input logic sel224, input logic [2:0] i);
    return sel224 ? IV224[i] : IV256[i];
  endfunction

  // Replaces a fetched word by its padded form; byte offsets use 40 bits so 4*g never wraps.
  function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [31:0] sz,
                                           input logic [31:0] blk, input logic last,
                                           input logic [3:0] j);
    logic [39:0] b, s;
    b = {2'b00, blk, 6'b000000} + {34'd0, j, 2'b00};
    s = {8'd0, sz};
    pad_word = 32'h0;
    if (b + 40'd4 <= s)
      pad_word = d;
    else if (b < s) begin
      case (s[1:0])
        2'd1:    pad_word = {d[31:24], 8'h80, 16'h0000};
        2'd2:    pad_word = {d[31:16], 8'h80, 8'h00};
        default: pad_word = {d[31:8], 8'h80};
      endcase
    end else if (b == s)
      pad_word = 32'h8000_0000;
    if (last && j == 4'd14)
      pad_word = {29'd0, sz[31:29]};
    if (last && j == 4'd15)
      pad_word = {sz[28:0], 3'b000};
  endfunction

  assign last_blk = (blk_r == nblk_r - 32'd1);
  assign more_blk = (blk_r < nblk_r - 32'd1);
  assign w_pad    = pad_word(mem_read_data, size_r, blk_r, last_blk, 4'(cnt - 7'd1));
  assign w_new    = s1(wv[14]) + wv[9] + s0(wv[1]) + wv[0];
  assign k_t      = K[cnt[5:0]];

  sha2_round u_round (
    .a(st[0]), .b(st[1]), .c(st[2]), .d(st[3]),
    .e(st[4]), .f(st[5]), .g(st[6]), .h(st[7]),
    .w(wv[0]), .k(k_t),
    .a_next(st_nxt[0]), .b_next(st_nxt[1]), .c_next(st_nxt[2]), .d_next(st_nxt[3]),
    .e_next(st_nxt[4]), .f_next(st_nxt[5]), .g_next(st_nxt[6]), .h_next(st_nxt[7])
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt != state) ? 7'd0 : cnt + 7'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = READ;
      READ:    if (cnt == 7'd16) state_nxt = COMPUTE;
      COMPUTE: if (cnt == 7'd63) state_nxt = UPDATE;
      UPDATE:  state_nxt = more_blk ? READ : WRITE;
      WRITE:   if (cnt == {3'b000, nw} - 7'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done           = 1'b0;
    busy           = (state != IDLE);
    mem_we         = 1'b0;
    mem_addr       = '0;
    mem_write_data = 32'h0;
    case (state)
      READ: if (cnt < 7'd16) mem_addr = msg_base + ADDR_W'(blk_r << 4) + ADDR_W'(cnt);
      WRITE: begin
        mem_we         = 1'b1;
        mem_addr       = out_base + ADDR_W'(cnt);
        mem_write_data = hv[cnt[2:0]];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: READ cycle 0 seeds a..h from H, cycles 1..16 shift in the padded words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_base <= '0;
      out_base <= '0;
      size_r   <= '0;
      nblk_r   <= '0;
      blk_r    <= '0;
      for (int i = 0; i < 8; i++) begin
        hv[i] <= '0;
        st[i] <= '0;
      end
      for (int i = 0; i < 16; i++) wv[i] <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          msg_base <= message_addr[ADDR_W-1:0];
          out_base <= output_addr[ADDR_W-1:0];
          size_r   <= size;
          nblk_r   <= ((size + 32'd8) >> 6) + 32'd1;
          blk_r    <= '0;
          for (int i = 0; i < 8; i++) hv[i] <= iv_word(mode_in, 3'(i));
        end
        READ: begin
          if (cnt == 7'd0) begin
            for (int i = 0; i < 8; i++) st[i] <= hv[i];
          end else begin
            for (int i = 0; i < 15; i++) wv[i] <= wv[i+1];
            wv[15] <= w_pad;
          end
        end
        COMPUTE: begin
          for (int i = 0; i < 8; i++) st[i] <= st_nxt[i];
          for (int i = 0; i < 15; i++) wv[i] <= wv[i+1];
          wv[15] <= w_new;
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) hv[i] <= hv[i] + st[i];
          if (more_blk) blk_r <= blk_r + 32'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_engine.sv
// Directed bench for sha2_engine: word memory model, write monitor, scoreboard of
// expected digest writes, and an independent byte-oriented SHA-2 reference model.
module tb_sha2_engine;
  import sha2_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mode;
  logic [31:0] message_addr, size, output_addr;
  logic        done, busy, mem_clk, mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_write_data, mem_read_data;

  always #5 clk = ~clk;

  sha2_engine #(.ADDR_W(16), .MSG_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .message_addr(message_addr), .size(size), .output_addr(output_addr),
    .done(done), .busy(busy), .mem_clk(mem_clk), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  logic [31:0] mem [0:65535];
  always @(posedge clk) mem_read_data <= mem[mem_addr];

  logic [15:0] obs_addr [0:255];
  logic [31:0] obs_data [0:255];
  int          obs_n  = 0;
  int          done_n = 0;

  always @(negedge clk) begin
    if (mem_we) begin
      obs_addr[obs_n[7:0]] <= mem_addr;
      obs_data[obs_n[7:0]] <= mem_write_data;
      obs_n <= obs_n + 1;
    end
    if (done) done_n <= done_n + 1;
  end

  typedef struct packed {logic [15:0] addr; logic [31:0] data;} wr_t;
  wr_t         exp_q [$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] ref_h [0:7];

  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [223:0] ABC224 = 224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7;

  int sz_tab   [7] = '{55, 56, 63, 64, 65, 119, 120};
  int nblk_tab [7] = '{1, 2, 2, 2, 2, 2, 3};

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic sha_model(input int maddr, input int sz, input bit m224);
    logic [7:0]  mb [0:511];
    logic [31:0] w [0:63];
    logic [31:0] hh [0:7];
    logic [31:0] va, vb, vc, vd, ve, vf, vg, vh, t1, t2, wd;
    logic [63:0] len;
    int nb;
    nb  = (sz + 9 + 63) / 64;
    len = 64'(sz) * 64'd8;
    for (int i = 0; i < nb * 64; i++) begin
      if (i < sz) begin
        wd    = mem[16'(maddr + i / 4)];
        mb[i] = wd[31 - 8 * (i % 4) -: 8];
      end else if (i == sz) mb[i] = 8'h80;
      else mb[i] = 8'h00;
    end
    for (int i = 0; i < 8; i++) mb[nb * 64 - 1 - i] = len[8 * i +: 8];
    for (int i = 0; i < 8; i++) hh[i] = m224 ? IV224[i] : IV256[i];
    for (int bk = 0; bk < nb; bk++) begin
      for (int t = 0; t < 16; t++)
        w[t] = {mb[bk*64+4*t], mb[bk*64+4*t+1], mb[bk*64+4*t+2], mb[bk*64+4*t+3]};
      for (int t = 16; t < 64; t++)
        w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
             + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
      {va, vb, vc, vd, ve, vf, vg, vh} = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
      for (int t = 0; t < 64; t++) begin
        t1 = vh + (rr(ve, 6) ^ rr(ve, 11) ^ rr(ve, 25)) + ((ve & vf) ^ (~ve & vg)) + K[t] + w[t];
        t2 = (rr(va, 2) ^ rr(va, 13) ^ rr(va, 22)) + ((va & vb) ^ (va & vc) ^ (vb & vc));
        vh = vg; vg = vf; vf = ve; ve = vd + t1;
        vd = vc; vc = vb; vb = va; va = t1 + t2;
      end
      hh[0] += va; hh[1] += vb; hh[2] += vc; hh[3] += vd;
      hh[4] += ve; hh[5] += vf; hh[6] += vg; hh[7] += vh;
    end
    for (int i = 0; i < 8; i++) ref_h[i] = hh[i];
  endtask

  task automatic push_exp(input int oaddr, input int nw, input logic [255:0] kat, input bit use_kat);
    wr_t e;
    for (int i = 0; i < nw; i++) begin
      e.addr = 16'(oaddr + i);
      e.data = use_kat ? kat[255 - 32 * i -: 32] : ref_h[i];
      exp_q.push_back(e);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the capture edge.
  task automatic begin_job(input int maddr, input int oaddr, input int sz, input bit md);
    message_addr = maddr;
    output_addr  = oaddr;
    size         = sz;
    mode         = md;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lat, input int pulse_n, input int hold_n,
                           input int hmaddr, input int hoaddr, input int hsz, output int n);
    n = 1;
    while (done !== 1'b1 && n < 3000) begin
      if (n == pulse_n) start = 1'b1;
      if (n == pulse_n + 1) start = 1'b0;
      if (n == hold_n) begin
        message_addr = hmaddr;
        output_addr  = hoaddr;
        size         = hsz;
        mode         = 1'b0;
        start        = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(lat));
    check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
  endtask

  task automatic check_writes(input string tag, input int nwords, input int ndone, input int ob, input int db);
    wr_t e;
    repeat (2) @(negedge clk);
    check({tag, "_write_count"}, 64'(obs_n - ob), 64'(nwords));
    check({tag, "_done_pulses"}, 64'(done_n - db), 64'(ndone));
    for (int i = 0; i < nwords; i++) begin
      e = exp_q.pop_front();
      check({tag, "_digest_word"}, {16'd0, obs_addr[8'(ob + i)], obs_data[8'(ob + i)]},
            {16'd0, e.addr, e.data});
    end
  endtask

  initial begin
    int n, ob, db, lat;
    for (int i = 0; i < 65536; i++) mem[i] = 32'hA5A5_A5A5;
    reset = 1'b1; start = 1'b0; mode = 1'b0;
    message_addr = '0; size = '0; output_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_write_data), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // "abc", one block
    mem[16'h0100] = 32'h6162_6300;
    ob = obs_n; db = done_n;
    push_exp(16'h0800, 8, ABC256, 1'b1);
    begin_job(16'h0100, 16'h0800, 3, 1'b0);
    wait_done("abc", 91, -1, -1, 0, 0, 0, n);
    check_writes("abc", 8, 1, ob, db);

    // empty message
    ob = obs_n; db = done_n;
    push_exp(16'h0810, 8, EMPTY, 1'b1);
    begin_job(16'h0200, 16'h0810, 0, 1'b0);
    wait_done("empty", 91, -1, -1, 0, 0, 0, n);
    check_writes("empty", 8, 1, ob, db);

    // mode=1: SHA-224 when enabled, otherwise ignored
    ob = obs_n; db = done_n;
`ifdef SHA2_SHA224_EN
    push_exp(16'h0820, 7, {ABC224, 32'h0}, 1'b1);
    begin_job(16'h0100, 16'h0820, 3, 1'b1);
    wait_done("abc224", 90, -1, -1, 0, 0, 0, n);
    check_writes("abc224", 7, 1, ob, db);
`else
    push_exp(16'h0820, 8, ABC256, 1'b1);
    begin_job(16'h0100, 16'h0820, 3, 1'b1);
    wait_done("mode_ignored", 91, -1, -1, 0, 0, 0, n);
    check_writes("mode_ignored", 8, 1, ob, db);
`endif

    // padding boundaries against the reference model
    for (int k = 0; k < 64; k++) mem[16'h1000 + k] = rr(32'h0123_4567, 32 - (k % 32));
    for (int idx = 0; idx < 7; idx++) begin
      ob = obs_n; db = done_n;
      sha_model(16'h1000, sz_tab[idx], 1'b0);
      push_exp(16'h0900 + 16 * idx, 8, '0, 1'b0);
      begin_job(16'h1000, 16'h0900 + 16 * idx, sz_tab[idx], 1'b0);
      lat = nblk_tab[idx] * 82 + 9;
      wait_done($sformatf("size%0d", sz_tab[idx]), lat, -1, -1, 0, 0, 0, n);
      check_writes($sformatf("size%0d", sz_tab[idx]), 8, 1, ob, db);
    end

    // reset at COMPUTE round 30, then a clean job
    ob = obs_n; db = done_n;
    begin_job(16'h0100, 16'h0A80, 3, 1'b0);
    repeat (47) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midreset_mem_we", 64'(mem_we), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("aborted_writes", 64'(obs_n - ob), 64'd0);
    check("aborted_done", 64'(done_n - db), 64'd0);
    push_exp(16'h0A80, 8, ABC256, 1'b1);
    begin_job(16'h0100, 16'h0A80, 3, 1'b0);
    wait_done("after_reset", 91, -1, -1, 0, 0, 0, n);
    check_writes("after_reset", 8, 1, ob, db);

    // start pulsed mid-job, then held through DONE into a second job
    ob = obs_n; db = done_n;
    sha_model(16'h1000, 64, 1'b0);
    push_exp(16'h0A00, 8, '0, 1'b0);
    push_exp(16'h0A20, 8, ABC256, 1'b1);
    begin_job(16'h1000, 16'h0A00, 64, 1'b0);
    wait_done("b2b_first", 173, 40, 150, 16'h0100, 16'h0A20, 3, n);
    @(negedge clk);
    check("b2b_idle_gap_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("b2b_second_captured", 64'(busy), 64'd1);
    start = 1'b0;
    wait_done("b2b_second", 91, -1, -1, 0, 0, 0, n);
    check_writes("b2b", 16, 2, ob, db);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
